// File: rtl/nios_audio_capture_fifo_if.sv
// nios_audio_capture_fifo_if: Avalon-MM slave bus plus interrupt between Nios II and the capture FIFO
interface nios_audio_capture_fifo_if;
    logic [2:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    modport master (output address, write, writedata, input readdata, irq);
    modport slave  (input address, write, writedata, output readdata, irq);
endinterface

// File: rtl/nios_audio_capture_fifo.sv
// nios_audio_capture_fifo: multi-channel audio frame FIFO with Avalon-MM peek/pop/status/threshold/irq
// Optional AUDIO_CAPTURE_SIGN_EXT_EN adds CTRL bit3 selecting sign extension of channel reads.
module nios_audio_capture_fifo #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    nios_audio_capture_fifo_if.slave bus,
    input  logic [NUM_CH*DATA_W-1:0] in_port,
    input  logic                     sample_valid
);
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = $clog2(DEPTH);

    logic [NUM_CH*DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]         wr_ptr, rd_ptr;
    logic [LVL_W-1:0]         level, level_nxt, thresh, thresh_nxt;
    logic                     enable, irq_en, irq_en_nxt, overflow, ovf_nxt, sext;
    logic                     ctrl_wr, status_wr, thresh_wr, pop_wr, flush, empty, full;
    logic                     push_req, do_push, do_pop, ovf_set;
    logic [NUM_CH*DATA_W-1:0] head;
    logic [DATA_W-1:0]        sample;
    logic [31:0]              ext, ctrl_rd, status_rd, rd_nxt;

    assign ctrl_wr   = bus.write & (bus.address == 3'd0);
    assign status_wr = bus.write & (bus.address == 3'd1);
    assign thresh_wr = bus.write & (bus.address == 3'd2);
    assign pop_wr    = bus.write & (bus.address == 3'd3);
    assign flush     = ctrl_wr & bus.writedata[2];
    assign empty     = level == '0;
    assign full      = level == LVL_W'(DEPTH);
    assign push_req  = enable & sample_valid & ~flush;
    assign do_pop    = pop_wr & ~empty & ~flush;
    // A pop frees the slot a same-cycle push needs, so full only drops frames without a pop
    assign do_push   = push_req & (~full | do_pop);
    assign ovf_set   = push_req & full & ~do_pop;
    assign level_nxt = flush ? '0 : level + LVL_W'(do_push) - LVL_W'(do_pop);
    assign ovf_nxt   = flush ? 1'b0 : ovf_set ? 1'b1 : (status_wr & bus.writedata[18]) ? 1'b0 : overflow;
    assign thresh_nxt = thresh_wr ? bus.writedata[LVL_W-1:0] : thresh;
    assign irq_en_nxt = ctrl_wr ? bus.writedata[1] : irq_en;
    assign head      = mem[rd_ptr];

`ifdef AUDIO_CAPTURE_SIGN_EXT_EN
    always_ff @(posedge clk) begin
        if (reset) sext <= 1'b1;
        else if (ctrl_wr) sext <= bus.writedata[3];
    end
`else
    assign sext = 1'b0;
`endif

    always_comb begin
        sample = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (bus.address[1:0] == 2'(i)) sample = head[i*DATA_W +: DATA_W];
    end

    assign ext       = sext ? 32'($signed(sample)) : 32'(sample);
    assign ctrl_rd   = {28'b0, sext, 1'b0, irq_en, enable};
    assign status_rd = 32'(level) | {13'b0, overflow, full, empty, 16'b0};
    assign rd_nxt    = bus.address == 3'd0 ? ctrl_rd :
                       bus.address == 3'd1 ? status_rd :
                       bus.address == 3'd2 ? 32'(thresh) :
                       (bus.address[2] & ~empty) ? ext : 32'b0;

    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= in_port;

    always_ff @(posedge clk) begin
        if (reset) begin
            enable        <= 1'b0;
            irq_en        <= 1'b0;
            thresh        <= '0;
            level         <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            overflow      <= 1'b0;
            bus.readdata  <= '0;
            bus.irq       <= 1'b0;
        end else begin
            bus.readdata <= rd_nxt;
            if (ctrl_wr) enable <= bus.writedata[0];
            irq_en   <= irq_en_nxt;
            thresh   <= thresh_nxt;
            level    <= level_nxt;
            overflow <= ovf_nxt;
            wr_ptr   <= flush ? '0 : wr_ptr + PTR_W'(do_push);
            rd_ptr   <= flush ? '0 : rd_ptr + PTR_W'(do_pop);
            bus.irq  <= irq_en_nxt & (ovf_nxt | ((thresh_nxt != '0) & (level_nxt >= thresh_nxt)));
        end
    end
endmodule

// File: tb/tb_nios_audio_capture_fifo.sv
// tb_nios_audio_capture_fifo: scoreboard bench for the audio capture FIFO (default 2ch x 16b x 16 deep)
module tb_nios_audio_capture_fifo;
    localparam int DEPTH = 16;
`ifdef AUDIO_CAPTURE_SIGN_EXT_EN
    localparam logic [31:0] SX = 32'h8;
`else
    localparam logic [31:0] SX = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] in_port = '0;
    logic        sample_valid = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] q [$];
    logic        m_en = 1'b0;
    logic        m_ovf = 1'b0;
    logic [31:0] d;

    nios_audio_capture_fifo_if bus ();

    nios_audio_capture_fifo #(.NUM_CH(2), .DATA_W(16), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .bus(bus), .in_port(in_port), .sample_valid(sample_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        int n = q.size();
        return 32'(n) | ((n == 0) ? 32'h10000 : 32'h0) | ((n == DEPTH) ? 32'h20000 : 32'h0) | (m_ovf ? 32'h40000 : 32'h0);
    endfunction

    task automatic wr(input logic [2:0] a, input logic [31:0] v);
        @(negedge clk);
        bus.address = a; bus.writedata = v; bus.write = 1'b1;
        @(negedge clk);
        bus.write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        @(negedge clk);
        bus.address = a; bus.write = 1'b0;
        @(negedge clk);
        v = bus.readdata;
    endtask

    task automatic push(input logic [31:0] f);
        @(negedge clk);
        in_port = f; sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        if (m_en) begin
            if (q.size() < DEPTH) q.push_back(f);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic pop();
        wr(3'd3, 32'h0);
        if (q.size() > 0) void'(q.pop_front());
    endtask

    task automatic check_head(input string tag);
        rd(3'd4, d);
        check({tag, "_ch0"}, d, q.size() ? {16'h0, q[0][15:0]} : 32'h0);
        rd(3'd5, d);
        check({tag, "_ch1"}, d, q.size() ? {16'h0, q[0][31:16]} : 32'h0);
    endtask

    task automatic check_status(input string tag);
        rd(3'd1, d);
        check(tag, d, exp_status());
    endtask

    initial begin
        bus.address = '0; bus.write = 1'b0; bus.writedata = '0;
        rd(3'd1, d);
        check("rst_readdata", d, 32'h0);
        check("rst_irq", {31'b0, bus.irq}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        check_status("rst_status");
        rd(3'd0, d);
        check("rst_ctrl", d, SX);

        wr(3'd0, SX | 32'h1); m_en = 1'b1;
        rd(3'd0, d);
        check("ctrl_rb", d, SX | 32'h1);
        push(32'hBEEF1234);
        check_status("one_status");
        check_head("one");
        rd(3'd6, d);
        check("unmapped_ch2", d, 32'h0);
        rd(3'd3, d);
        check("pop_reads0", d, 32'h0);
        pop();
        check_status("one_popped");
        pop();
        check_status("pop_empty");
        check_head("empty");

        for (int i = 0; i < DEPTH + 1; i++) push({16'(i + 16'h100), 16'(i * 3 + 1)});
        check_status("overflow_status");
        check_head("overflow_head");
        wr(3'd1, 32'h40000); m_ovf = 1'b0;
        check_status("ovf_cleared");

        @(negedge clk);
        in_port = 32'hCAFE5A5A; sample_valid = 1'b1;
        bus.address = 3'd3; bus.write = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0; bus.write = 1'b0;
        void'(q.pop_front()); q.push_back(32'hCAFE5A5A);
        check_status("full_pushpop");
        for (int i = 0; i < DEPTH; i++) begin
            check_head($sformatf("drain%0d", i));
            pop();
        end
        check_status("drained");

        @(negedge clk);
        in_port = 32'h00770066; sample_valid = 1'b1;
        bus.address = 3'd3; bus.write = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0; bus.write = 1'b0;
        q.push_back(32'h00770066);
        check_status("empty_pushpop");
        check_head("empty_pushpop");
        pop();

        wr(3'd2, 32'h4);
        rd(3'd2, d);
        check("thresh_rb", d, 32'h4);
        wr(3'd0, SX | 32'h3);
        for (int i = 0; i < 3; i++) begin
            push(32'h1000 + 32'(i));
            check($sformatf("irq_low%0d", i), {31'b0, bus.irq}, 32'h0);
        end
        push(32'h2000);
        check("irq_high", {31'b0, bus.irq}, 32'h1);
        pop();
        check("irq_after_pop", {31'b0, bus.irq}, 32'h0);
        push(32'h3000);
        check("irq_again", {31'b0, bus.irq}, 32'h1);
        wr(3'd0, SX | 32'h7);
        q.delete();
        check_status("flushed");
        check("irq_flushed", {31'b0, bus.irq}, 32'h0);
        rd(3'd0, d);
        check("ctrl_after_flush", d, SX | 32'h3);

        wr(3'd0, SX | 32'h1);
        push(32'h8001_8001);
        rd(3'd4, d);
        check("ext_ch0", d, (SX != 0) ? 32'hFFFF8001 : 32'h00008001);
        wr(3'd0, 32'h1);
        rd(3'd5, d);
        check("zext_ch1", d, 32'h00008001);
        pop();

        wr(3'd0, 32'h0); m_en = 1'b0;
        push(32'h12345678);
        check_status("disabled");
        wr(3'd0, 32'h1); m_en = 1'b1;
        push(32'h11112222);
        push(32'h33334444);
        check_status("pre_reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        q.delete(); m_en = 1'b0;
        check_status("mid_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
